// File: rtl/mem_sram_ctrl.sv
// Round-robin read/write request controller in front of one single-port SRAM bank.
// Registered issue stage, two-stage read tracking, and a credit-protected response FIFO.
module mem_sram_ctrl #(
   parameter logic [3:0] BANK_ID   = 4'd0,
   parameter int         RSP_DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_wr_valid,
   output logic         o_wr_ready,
   input  logic [18:0]  i_wr_addr,
   input  logic [255:0] i_wr_data,
   input  logic         i_wr_mask_en,
   input  logic [255:0] i_wr_mask,
   input  logic         i_rd_valid,
   output logic         o_rd_ready,
   input  logic [18:0]  i_rd_addr,
   output logic         o_rsp_valid,
   input  logic         i_rsp_ready,
   output logic [255:0] o_rsp_data,
   output logic         o_rsp_err,
   output logic         o_wr_err,
   output logic         o_sram_cs,
   output logic         o_sram_read,
   output logic         o_sram_write,
   output logic         o_sram_mask_enable,
   output logic [3:0]   o_sram_id,
   output logic [18:0]  o_sram_addr,
   output logic [255:0] o_sram_data_in,
   output logic [255:0] o_sram_mask,
   input  logic [255:0] i_sram_data_out
);
   localparam int AW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
   localparam int CW = $clog2(RSP_DEPTH + 3);

   typedef enum logic {RR_WR = 1'b0, RR_RD = 1'b1} rr_e;

   rr_e            r_rr;
   logic           r_run;
   logic [2:1]     r_vld_pipe;
   logic [2:1]     r_err_pipe;
   logic [AW-1:0]  r_wp, r_rp;
   logic [CW-1:0]  r_count;
   logic [255:0]   r_mem [RSP_DEPTH];
   logic           r_err_mem [RSP_DEPTH];

   logic [CW-1:0]  w_reserved;
   logic           w_rd_elig, w_gnt_wr, w_gnt_rd, w_wr_acc, w_rd_acc;
   logic           w_wr_inb, w_rd_inb, w_contend, w_push, w_pop;

   function automatic logic [AW-1:0] f_inc(input logic [AW-1:0] p);
      return (p == AW'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // Reads still in the issue/capture stages already own a FIFO slot.
   assign w_reserved = CW'(r_vld_pipe[1]) + CW'(r_vld_pipe[2]) + r_count;
   assign w_rd_elig  = i_rd_valid && (w_reserved < CW'(RSP_DEPTH));
   assign w_contend  = i_wr_valid && w_rd_elig;
   assign w_gnt_wr   = i_wr_valid && (!w_rd_elig || r_rr == RR_WR);
   assign w_gnt_rd   = w_rd_elig && (!i_wr_valid || r_rr == RR_RD);
   assign o_wr_ready = w_gnt_wr && r_run;
   assign o_rd_ready = w_gnt_rd && r_run;
   assign w_wr_acc   = o_wr_ready;
   assign w_rd_acc   = o_rd_ready;
   assign w_wr_inb   = (i_wr_addr[18:15] == BANK_ID);
   assign w_rd_inb   = (i_rd_addr[18:15] == BANK_ID);

   assign o_sram_id  = BANK_ID;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_run              <= 1'b0;
         r_rr               <= RR_WR;
         r_vld_pipe         <= '0;
         r_err_pipe         <= '0;
         o_wr_err           <= 1'b0;
         o_sram_cs          <= 1'b0;
         o_sram_read        <= 1'b0;
         o_sram_write       <= 1'b0;
         o_sram_mask_enable <= 1'b0;
         o_sram_addr        <= '0;
         o_sram_data_in     <= '0;
         o_sram_mask        <= '0;
      end else begin
         r_run              <= 1'b1;
         r_vld_pipe         <= {r_vld_pipe[1], w_rd_acc};
         r_err_pipe         <= {r_err_pipe[1], w_rd_acc && !w_rd_inb};
         o_wr_err           <= w_wr_acc && !w_wr_inb;
         o_sram_cs          <= (w_wr_acc && w_wr_inb) || (w_rd_acc && w_rd_inb);
         o_sram_read        <= w_rd_acc && w_rd_inb;
         o_sram_write       <= w_wr_acc && w_wr_inb;
         o_sram_mask_enable <= w_wr_acc && w_wr_inb && i_wr_mask_en;
         if (w_wr_acc && w_wr_inb) begin
            o_sram_addr    <= i_wr_addr;
            o_sram_data_in <= i_wr_data;
            o_sram_mask    <= i_wr_mask;
         end else if (w_rd_acc && w_rd_inb) begin
            o_sram_addr    <= i_rd_addr;
         end
         if (w_contend) r_rr <= w_gnt_wr ? RR_RD : RR_WR;
      end
   end

   // Out-of-bank reads travel the same pipe so responses stay in request order.
   assign w_push      = r_vld_pipe[2];
   assign w_pop       = (r_count != '0) && i_rsp_ready;
   assign o_rsp_valid = (r_count != '0);
   assign o_rsp_data  = o_rsp_valid ? r_mem[r_rp] : '0;
   assign o_rsp_err   = o_rsp_valid && r_err_mem[r_rp];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wp    <= '0;
         r_rp    <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wp <= f_inc(r_wp);
         if (w_pop)  r_rp <= f_inc(r_rp);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wp]     <= r_err_pipe[2] ? '0 : i_sram_data_out;
         r_err_mem[r_wp] <= r_err_pipe[2];
      end
   end

   a_no_rw: assert property (@(posedge clk) disable iff (!rst_n)
      !(o_sram_read && o_sram_write));
   a_bank: assert property (@(posedge clk) disable iff (!rst_n)
      o_sram_cs |-> (o_sram_addr[18:15] == BANK_ID));
   a_no_ovf: assert property (@(posedge clk) disable iff (!rst_n)
      !(w_push && !w_pop && r_count == CW'(RSP_DEPTH)));
endmodule

// File: tb/tb_mem_sram_ctrl.sv
// Directed bench for mem_sram_ctrl (BANK_ID=1) with a behavioural bank model.
module tb_mem_sram_ctrl;
   logic         clk = 1'b0, rst_n = 1'b0;
   logic         wr_valid = 1'b0, wr_ready, wr_mask_en = 1'b0;
   logic [18:0]  wr_addr = '0, rd_addr = '0;
   logic [255:0] wr_data = '0, wr_mask = '0;
   logic         rd_valid = 1'b0, rd_ready;
   logic         rsp_valid, rsp_ready = 1'b1, rsp_err, wr_err;
   logic [255:0] rsp_data;
   logic         sram_cs, sram_read, sram_write, sram_mask_enable;
   logic [3:0]   sram_id;
   logic [18:0]  sram_addr;
   logic [255:0] sram_data_in, sram_mask;
   logic [255:0] sram_data_out = '0;

   int n_chk = 0, n_err = 0;

   always #5 clk = ~clk;

   mem_sram_ctrl #(.BANK_ID(4'd1), .RSP_DEPTH(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_wr_valid(wr_valid), .o_wr_ready(wr_ready), .i_wr_addr(wr_addr),
      .i_wr_data(wr_data), .i_wr_mask_en(wr_mask_en), .i_wr_mask(wr_mask),
      .i_rd_valid(rd_valid), .o_rd_ready(rd_ready), .i_rd_addr(rd_addr),
      .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_data(rsp_data),
      .o_rsp_err(rsp_err), .o_wr_err(wr_err),
      .o_sram_cs(sram_cs), .o_sram_read(sram_read), .o_sram_write(sram_write),
      .o_sram_mask_enable(sram_mask_enable), .o_sram_id(sram_id),
      .o_sram_addr(sram_addr), .o_sram_data_in(sram_data_in),
      .o_sram_mask(sram_mask), .i_sram_data_out(sram_data_out));

   // Bank model: OR-merge on masked writes, read data one cycle after sampling.
   bit [255:0] bank [1024];
   always @(posedge clk) begin
      if (sram_cs && sram_write)
         bank[sram_addr[14:5]] <= sram_mask_enable ?
            (bank[sram_addr[14:5]] | (sram_data_in & sram_mask)) : sram_data_in;
      if (sram_cs && sram_read)
         sram_data_out <= bank[sram_addr[14:5]];
   end

   task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", nm, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         chk("bank_port_legal",
             {255'd0, (sram_read && sram_write) || (sram_cs && sram_addr[18:15] != 4'd1)}, '0);
      end
   end

   function automatic logic [18:0] la(input int line);
      logic [9:0] l;
      l = line[9:0];
      return {4'd1, l, 5'd0};
   endfunction

   typedef struct {
      bit           wr;
      logic [18:0]  addr;
      logic [255:0] data;
      bit           men;
      logic [255:0] mask;
      logic [255:0] exp;
      bit           oob;
   } vec_t;

   localparam logic [255:0] A    = {8{32'h1234_5678}};
   localparam logic [255:0] ONES = {256{1'b1}};
   localparam logic [255:0] LO   = {128'd0, {128{1'b1}}};

   task automatic run_vec(input vec_t v);
      bit inb;
      int n;
      inb = (v.addr[18:15] == 4'd1);
      @(negedge clk);
      if (v.wr) begin
         wr_valid = 1'b1; wr_addr = v.addr; wr_data = v.data;
         wr_mask_en = v.men; wr_mask = v.mask;
      end else begin
         rd_valid = 1'b1; rd_addr = v.addr;
      end
      #1; n = 0;
      while (!(v.wr ? wr_ready : rd_ready) && n < 20) begin @(negedge clk); #1; n++; end
      chk("hs_timeout", {255'd0, n >= 20}, '0);
      @(posedge clk); #1;
      wr_valid = 1'b0; rd_valid = 1'b0;
      chk("issue_cs", {255'd0, sram_cs}, {255'd0, inb});
      if (v.wr) begin
         chk("issue_write", {255'd0, sram_write}, {255'd0, inb});
         chk("wr_err_pulse", {255'd0, wr_err}, {255'd0, v.oob});
         if (inb) begin
            chk("issue_data", sram_data_in, v.data);
            chk("issue_men", {255'd0, sram_mask_enable}, {255'd0, v.men});
         end
      end else begin
         chk("issue_read", {255'd0, sram_read}, {255'd0, inb});
         if (inb) chk("issue_addr", {237'd0, sram_addr}, {237'd0, v.addr});
      end
      @(posedge clk); #1;
      if (v.wr) chk("wr_err_end", {255'd0, wr_err}, '0);
      else begin
         chk("rsp_early", {255'd0, rsp_valid}, '0);
         @(posedge clk); #1;
         chk("rsp_lat2", {255'd0, rsp_valid}, 256'd1);
         chk("rsp_data", rsp_data, v.exp);
         chk("rsp_err", {255'd0, rsp_err}, {255'd0, v.oob});
      end
   endtask

   task automatic chk_reset_outs(input string nm);
      chk({nm, "_ready"}, {254'd0, wr_ready, rd_ready}, '0);
      chk({nm, "_ctl"}, {252'd0, sram_cs, sram_read, sram_write, sram_mask_enable}, '0);
      chk({nm, "_addr"}, {237'd0, sram_addr}, '0);
      chk({nm, "_din"}, sram_data_in | sram_mask, '0);
      chk({nm, "_rsp"}, {254'd0, rsp_valid, rsp_err} | rsp_data, '0);
      chk({nm, "_wrerr"}, {255'd0, wr_err}, '0);
      chk({nm, "_id"}, {252'd0, sram_id}, 256'd1);
   endtask

   vec_t         vecs [10];
   logic [255:0] bp_exp [6];

   initial begin
      int acc, got, n;
      bit hs, rsp_hs;
      vecs[0] = '{1, la(12'h40), A, 0, '0, '0, 0};
      vecs[1] = '{0, la(12'h40), '0, 0, '0, A, 0};
      vecs[2] = '{1, la(12'h41), {32{8'hF0}}, 0, '0, '0, 0};
      vecs[3] = '{1, la(12'h41), {32{8'h0F}}, 1, ONES, '0, 0};
      vecs[4] = '{0, la(12'h41), '0, 0, '0, ONES, 0};
      vecs[5] = '{0, 19'h10000, '0, 0, '0, '0, 1};
      vecs[6] = '{1, 19'h00020, ONES, 0, '0, '0, 1};
      vecs[7] = '{0, la(12'h40), '0, 0, '0, A, 0};
      vecs[8] = '{1, la(12'h40), ONES, 1, LO, '0, 0};
      vecs[9] = '{0, la(12'h40), '0, 0, '0, {{4{32'h1234_5678}}, {128{1'b1}}}, 0};

      // Reset state, with both requesters pushing.
      wr_valid = 1'b1; rd_valid = 1'b1; wr_addr = la(1); rd_addr = la(1);
      #12;
      chk_reset_outs("reset");
      @(negedge clk);
      wr_valid = 1'b0; rd_valid = 1'b0;
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      foreach (vecs[i]) run_vec(vecs[i]);

      // Contention: strict alternation starting with the write side.
      rsp_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         wr_valid = 1'b1; wr_addr = la(12'h70); wr_data = ONES; wr_mask_en = 1'b0;
         rd_valid = 1'b1; rd_addr = la(12'h71);
         #1;
         chk("contend_gnt", {254'd0, wr_ready, rd_ready},
             (i % 2 == 0) ? 256'd2 : 256'd1);
      end
      @(negedge clk);
      wr_valid = 1'b0; rd_valid = 1'b0;
      repeat (6) @(negedge clk);
      chk("contend_drain", {255'd0, rsp_valid}, '0);

      // Backpressure: preload six lines, then read them with rsp_ready low.
      for (int k = 0; k < 6; k++) begin
         bp_exp[k] = {8{32'hC0DE_0000 + 32'(k)}};
         run_vec('{1, la(12'h50 + k), bp_exp[k], 0, '0, '0, 0});
      end
      rsp_ready = 1'b0;
      acc = 0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         rd_valid = 1'b1; rd_addr = la(12'h50 + acc);
         #1; hs = rd_ready;
         @(posedge clk);
         if (hs) acc++;
      end
      chk("bp_accepted", 256'(acc), 256'd4);
      @(negedge clk);
      rd_addr = la(12'h50 + acc);
      wr_valid = 1'b1; wr_addr = la(12'h60); wr_data = ONES; wr_mask_en = 1'b0;
      #1;
      chk("bp_ready", {254'd0, wr_ready, rd_ready}, 256'd2);
      @(posedge clk); #1;
      wr_valid = 1'b0;
      chk("bp_wr_issue", {255'd0, sram_write}, 256'd1);
      rsp_ready = 1'b1;
      got = 0; n = 0;
      while (got < 6 && n < 40) begin
         @(negedge clk);
         rd_valid = (acc < 6); rd_addr = la(12'h50 + acc);
         #1;
         hs = rd_valid && rd_ready;
         rsp_hs = rsp_valid;
         if (rsp_hs) begin
            chk("bp_order", rsp_data, bp_exp[got]);
            got++;
         end
         @(posedge clk);
         if (hs) acc++;
         n++;
      end
      rd_valid = 1'b0;
      chk("bp_all_returned", 256'(got), 256'd6);

      // Reset while a read is in flight.
      repeat (3) @(negedge clk);
      rd_valid = 1'b1; rd_addr = la(12'h40);
      #1; chk("mid_rd_ready", {255'd0, rd_ready}, 256'd1);
      @(posedge clk); #1;
      rd_valid = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk_reset_outs("midreset");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk("midreset_no_rsp", {255'd0, rsp_valid}, '0);
      end
      run_vec(vecs[9]);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout got=running exp=finished");
      $fatal(1);
   end
endmodule
